icache_linefill_rsp: RTL

//  Receive end of the icache downstream linefill protocol. Records the index/way of every linefill request
//  on the txreq handshake, then collects the downstream read-data beats for that txnid into one line.

---
 rtl/icache_linefill_rsp_pkg.sv | 37 +++
 rtl/icache_linefill_ctx_tbl.sv | 56 +++++
 rtl/icache_linefill_rsp.sv | 130 +++++++++++++
 3 files changed

// File: rtl/icache_linefill_rsp_pkg.sv
// Shared types and sizing for the icache linefill response path.
package icache_linefill_rsp_pkg;
  localparam int MSHR_ENTRY_NUM = 8;
  localparam int TXNID_W        = $clog2(MSHR_ENTRY_NUM);
  localparam int INDEX_W        = 6;
  localparam int WAY_NUM        = 2;
  localparam int WAY_W          = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1;
  localparam int LF_BEAT_W      = 128;
  localparam int LF_BEAT_NUM    = 4;
  localparam int LF_LINE_W      = LF_BEAT_W * LF_BEAT_NUM;
  localparam int BEAT_CNT_W     = (LF_BEAT_NUM > 1) ? $clog2(LF_BEAT_NUM) : 1;

  typedef struct packed {
    logic [INDEX_W-1:0] index;
    logic [WAY_W-1:0]   way;
  } linefill_ctx_t;

  typedef struct packed {
    logic [INDEX_W-1:0]   index;
    logic [WAY_W-1:0]     way;
    logic [LF_LINE_W-1:0] data;
  } dataram_wr_pld_t;

  typedef struct packed {
    logic [TXNID_W-1:0]   txnid;
    logic                 last;
    logic [LF_BEAT_W-1:0] data;
  } rxdat_pld_t;

  localparam int LF_WR_PLD_W = $bits(dataram_wr_pld_t);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_WRITE   = 2'd1,
    ST_DONE    = 2'd2
  } lf_state_e;
endpackage

// File: rtl/icache_linefill_ctx_tbl.sv
// Per-txnid linefill context table: {index, way} plus an outstanding bit per slot.
module icache_linefill_ctx_tbl
  import icache_linefill_rsp_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_wr_en,
  input  logic [TXNID_W-1:0]        i_wr_id,
  input  logic [INDEX_W-1:0]        i_wr_index,
  input  logic [WAY_W-1:0]          i_wr_way,
  input  logic                      i_clr_en,
  input  logic [TXNID_W-1:0]        i_clr_id,
  input  logic [TXNID_W-1:0]        i_rd_id,
  output logic [INDEX_W-1:0]        o_rd_index,
  output logic [WAY_W-1:0]          o_rd_way,
  output logic [MSHR_ENTRY_NUM-1:0] o_valid
);
  linefill_ctx_t w_ctx_arr [MSHR_ENTRY_NUM];
  linefill_ctx_t w_wr_ctx;
  linefill_ctx_t w_rd_ctx;

  assign w_wr_ctx.index = i_wr_index;
  assign w_wr_ctx.way   = i_wr_way;

  genvar gi;
  generate
    for (gi = 0; gi < MSHR_ENTRY_NUM; gi++) begin : g_slot
      linefill_ctx_t r_ctx;
      logic          r_valid;
      logic          w_wr;
      logic          w_clr;

      assign w_wr  = i_wr_en  && (i_wr_id  == TXNID_W'(gi));
      assign w_clr = i_clr_en && (i_clr_id == TXNID_W'(gi));

      // A capture landing on the same cycle as the done-clear keeps the slot live.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_ctx   <= '0;
          r_valid <= 1'b0;
        end else begin
          if (w_wr) r_ctx <= w_wr_ctx;
          if (w_wr)       r_valid <= 1'b1;
          else if (w_clr) r_valid <= 1'b0;
        end
      end

      assign w_ctx_arr[gi] = r_ctx;
      assign o_valid[gi]   = r_valid;
    end
  endgenerate

  assign w_rd_ctx   = w_ctx_arr[i_rd_id];
  assign o_rd_index = w_rd_ctx.index;
  assign o_rd_way   = w_rd_ctx.way;
endmodule

// File: rtl/icache_linefill_rsp.sv
// Linefill receive path: snoops txreq for ctx, gathers rx beats into a line,
// writes it to the dataram and pulses the owning MSHR entry's done.
module icache_linefill_rsp
  import icache_linefill_rsp_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      txreq_vld,
  input  logic                      txreq_rdy,
  input  logic [TXNID_W-1:0]        txreq_txnid,
  input  logic [INDEX_W-1:0]        txreq_index,
  input  logic [WAY_W-1:0]          txreq_way,
  input  logic                      rxdat_vld,
  output logic                      rxdat_rdy,
  input  logic [TXNID_W-1:0]        rxdat_txnid,
  input  logic                      rxdat_last,
  input  logic [LF_BEAT_W-1:0]      rxdat_data,
  output logic                      dataram_wr_vld,
  input  logic                      dataram_wr_rdy,
  output logic [LF_WR_PLD_W-1:0]    dataram_wr_pld,
  output logic [MSHR_ENTRY_NUM-1:0] v_linefill_done,
  output logic [MSHR_ENTRY_NUM-1:0] ctx_valid,
  output logic                      proto_err
);
  lf_state_e                 r_state;
  lf_state_e                 w_state_next;
  logic [BEAT_CNT_W-1:0]     r_beat_cnt;
  logic [TXNID_W-1:0]        r_cur_txnid;
  logic                      r_proto_err;
  logic [LF_LINE_W-1:0]      w_line;
  logic [INDEX_W-1:0]        w_rd_index;
  logic [WAY_W-1:0]          w_rd_way;
  logic [MSHR_ENTRY_NUM-1:0] w_ctx_valid;
  rxdat_pld_t                w_rx;
  dataram_wr_pld_t           w_pld;
  logic                      w_beat_hs;
  logic                      w_beat_final;
  logic                      w_cap;
  logic                      w_clr;
  logic                      w_err_cap;
  logic                      w_err_beat;

  assign w_rx.txnid = rxdat_txnid;
  assign w_rx.last  = rxdat_last;
  assign w_rx.data  = rxdat_data;

  assign w_beat_hs    = rxdat_vld && rxdat_rdy;
  assign w_beat_final = (r_beat_cnt == BEAT_CNT_W'(LF_BEAT_NUM - 1));
  assign w_cap        = txreq_vld && txreq_rdy;
  assign w_clr        = (r_state == ST_DONE);

  icache_linefill_ctx_tbl u_ctx_tbl (
    .clk        (clk),
    .rst        (rst),
    .i_wr_en    (w_cap),
    .i_wr_id    (txreq_txnid),
    .i_wr_index (txreq_index),
    .i_wr_way   (txreq_way),
    .i_clr_en   (w_clr),
    .i_clr_id   (r_cur_txnid),
    .i_rd_id    (r_cur_txnid),
    .o_rd_index (w_rd_index),
    .o_rd_way   (w_rd_way),
    .o_valid    (w_ctx_valid)
  );

  // Re-capturing a slot that is being released this cycle is a legal reuse, not a collision.
  assign w_err_cap  = w_cap && w_ctx_valid[txreq_txnid] && !(w_clr && (r_cur_txnid == txreq_txnid));
  assign w_err_beat = w_beat_hs &&
                      (((r_beat_cnt != '0) && (w_rx.txnid != r_cur_txnid)) ||
                       !w_ctx_valid[w_rx.txnid] ||
                       (w_rx.last != w_beat_final));

  genvar gi;
  generate
    for (gi = 0; gi < LF_BEAT_NUM; gi++) begin : g_beat
      logic [LF_BEAT_W-1:0] r_buf;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)                                                r_buf <= '0;
        else if (w_beat_hs && (r_beat_cnt == BEAT_CNT_W'(gi))) r_buf <= w_rx.data;
      end
      assign w_line[gi*LF_BEAT_W +: LF_BEAT_W] = r_buf;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_COLLECT;
      r_beat_cnt  <= '0;
      r_cur_txnid <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_proto_err <= r_proto_err | w_err_cap | w_err_beat;
      if (w_beat_hs) begin
        r_beat_cnt <= w_beat_final ? '0 : r_beat_cnt + 1'b1;
        if (r_beat_cnt == '0) r_cur_txnid <= w_rx.txnid;
      end
    end
  end

  always_comb begin
    w_state_next    = r_state;
    rxdat_rdy       = 1'b0;
    dataram_wr_vld  = 1'b0;
    v_linefill_done = '0;
    case (r_state)
      ST_COLLECT: begin
        rxdat_rdy = !rst;
        if (w_beat_hs && w_beat_final) w_state_next = ST_WRITE;
      end
      ST_WRITE: begin
        dataram_wr_vld = 1'b1;
        if (dataram_wr_rdy) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        v_linefill_done[r_cur_txnid] = 1'b1;
        w_state_next                 = ST_COLLECT;
      end
      default: w_state_next = ST_COLLECT;
    endcase
  end

  assign w_pld.index    = w_rd_index;
  assign w_pld.way      = w_rd_way;
  assign w_pld.data     = w_line;
  assign dataram_wr_pld = w_pld;
  assign ctx_valid      = w_ctx_valid;
  assign proto_err      = r_proto_err;
endmodule
